// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Shares the single register-file write port between two write-back
//   requesters (req0: ALU result, req1: memory load return). Requests are
//   arbitrated round-robin with valid/ready handshakes. The winner is latched
//   into the write port, so one write commits per cycle with a latency of one
//   cycle. A busy scoreboard records destination registers claimed at issue,
//   which lets decode stall on an outstanding write.
//
// Parameters:
//   REG_WIDTH  data width of a register
//   NUM_REGS   number of architectural registers
//   RD_WIDTH   register index width
//
// Ports:
//   CLK          in   clock; all state updates on the rising edge
//   RST          in   synchronous reset, active-high
//   req0_valid   in   requester 0 has a write pending
//   req0_rd      in   requester 0 destination index
//   req0_data    in   requester 0 write data
//   req0_ready   out  requester 0 granted this cycle (handshake = valid & ready)
//   req1_*            same as req0, for requester 1
//   claim_valid  in   issue stage marks claim_rd as pending
//   claim_rd     in   register being claimed
//   claim_ready  out  high when claim_rd is not busy; a claim is taken only then
//   wr_en        out  register file write enable
//   wr_rd        out  register file write index
//   wr_data      out  register file write data
//   busy         out  scoreboard, bit i = register i has an outstanding write
//
// Configuration:
//   WB_REG0_DROP_EN  when defined, register 0 is hard zero: handshakes with
//                    rd=0 complete but never raise wr_en, and claims of rd=0
//                    are accepted without marking busy[0].
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int REG_WIDTH = 32,
  parameter int NUM_REGS  = 32,
  parameter int RD_WIDTH  = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req0_valid,
  input  logic [RD_WIDTH-1:0]  req0_rd,
  input  logic [REG_WIDTH-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [RD_WIDTH-1:0]  req1_rd,
  input  logic [REG_WIDTH-1:0] req1_data,
  output logic                 req1_ready,
  input  logic                 claim_valid,
  input  logic [RD_WIDTH-1:0]  claim_rd,
  output logic                 claim_ready,
  output logic                 wr_en,
  output logic [RD_WIDTH-1:0]  wr_rd,
  output logic [REG_WIDTH-1:0] wr_data,
  output logic [NUM_REGS-1:0]  busy
);

  // Scoreboard bits that are allowed to become set.
`ifdef WB_REG0_DROP_EN
  localparam logic [NUM_REGS-1:0] TRACK_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};
`else
  localparam logic [NUM_REGS-1:0] TRACK_MASK = {NUM_REGS{1'b1}};
`endif

  // One-hot decode of a register index; indices >= NUM_REGS give an all-zero
  // mask, so out-of-range indices never touch the scoreboard.
  function automatic logic [NUM_REGS-1:0] decode_idx(input logic [RD_WIDTH-1:0] idx);
    logic [NUM_REGS-1:0] dec;
    dec = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      dec[i] = (idx == RD_WIDTH'(i));
    end
    return dec;
  endfunction

  // last_grant_r: 1'b1 = req1 won the most recent handshake, so req0 has
  // priority next time both are valid. Reset to 1'b1 so req0 wins first.
  logic                 last_grant_r;
  logic                 wr_en_r;
  logic [RD_WIDTH-1:0]  wr_rd_r;
  logic [REG_WIDTH-1:0] wr_data_r;
  logic [NUM_REGS-1:0]  busy_r;

  logic                 grant0_s;
  logic                 grant1_s;
  logic                 handshake_s;
  logic [RD_WIDTH-1:0]  win_rd_s;
  logic [REG_WIDTH-1:0] win_data_s;
  logic                 drop_s;
  logic                 claim_hit_s;
  logic                 claim_acc_s;
  logic [NUM_REGS-1:0]  busy_next_s;

  // Round-robin grant; nothing is granted while reset is asserted.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (RST) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else begin
      case ({req0_valid, req1_valid})
        2'b10: grant0_s = 1'b1;
        2'b01: grant1_s = 1'b1;
        2'b11: begin
          grant0_s = last_grant_r;
          grant1_s = ~last_grant_r;
        end
        default: begin
          grant0_s = 1'b0;
          grant1_s = 1'b0;
        end
      endcase
    end
  end

  assign req0_ready  = grant0_s;
  assign req1_ready  = grant1_s;
  assign handshake_s = (grant0_s & req0_valid) | (grant1_s & req1_valid);

  // Select the destination and data of the granted requester.
  always_comb begin
    win_rd_s   = req0_rd;
    win_data_s = req0_data;
    if (grant1_s) begin
      win_rd_s   = req1_rd;
      win_data_s = req1_data;
    end else begin
      win_rd_s   = req0_rd;
      win_data_s = req0_data;
    end
  end

  // A handshake to the hard-zero register still completes but never writes.
`ifdef WB_REG0_DROP_EN
  assign drop_s = (win_rd_s == {RD_WIDTH{1'b0}});
`else
  assign drop_s = 1'b0;
`endif

  // A claim is blocked only by a pending write to the same tracked register.
  assign claim_hit_s = |(decode_idx(claim_rd) & busy_r);
  assign claim_ready = ~RST & ~claim_hit_s;
  assign claim_acc_s = claim_valid & claim_ready;

  // Scoreboard next state: clear on commit first, then set on claim, so a
  // same-edge set and clear of one index leaves the bit set.
  always_comb begin
    busy_next_s = busy_r;
    if (wr_en_r) begin
      busy_next_s = busy_next_s & ~decode_idx(wr_rd_r);
    end else begin
      busy_next_s = busy_r;
    end
    if (claim_acc_s) begin
      busy_next_s = busy_next_s | (decode_idx(claim_rd) & TRACK_MASK);
    end else begin
      busy_next_s = busy_next_s;
    end
  end

  // Write-port latch, arbitration history and scoreboard state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant_r <= 1'b1;
      wr_en_r      <= 1'b0;
      wr_rd_r      <= {RD_WIDTH{1'b0}};
      wr_data_r    <= {REG_WIDTH{1'b0}};
      busy_r       <= {NUM_REGS{1'b0}};
    end else begin
      if (handshake_s) begin
        last_grant_r <= grant1_s;
        wr_en_r      <= ~drop_s;
        wr_rd_r      <= win_rd_s;
        wr_data_r    <= win_data_s;
      end else begin
        wr_en_r      <= 1'b0;
      end
      busy_r <= busy_next_s;
    end
  end

  // A write still sitting in the latch when reset arrives is suppressed so the
  // register file never commits it; requesters re-present it afterwards.
  assign wr_en   = wr_en_r & ~RST;
  assign wr_rd   = wr_rd_r;
  assign wr_data = wr_data_r;
  assign busy    = busy_r;

endmodule
